// File: rtl/dmem_pkg.sv
// Shared encodings, state enum and access-legality helpers for the RMW data-memory controller.
package dmem_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned SLT_W        = 4;
  localparam int unsigned OFF_W        = 2;
  localparam int unsigned SL_STORE_BIT = 3;

  localparam logic [2:0] SL_B  = 3'b000;
  localparam logic [2:0] SL_H  = 3'b001;
  localparam logic [2:0] SL_W  = 3'b010;
  localparam logic [2:0] SL_BU = 3'b100;
  localparam logic [2:0] SL_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } state_t;

  // Request fields kept for the whole operation.
  typedef struct packed {
    logic [OFF_W-1:0]  offset;
    logic [SLT_W-1:0]  sltype;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Unknown size codes, and unsigned variants used as stores, are illegal.
  function automatic logic is_illegal(logic [SLT_W-1:0] sltype);
    logic bad;
    case (sltype[2:0])
      SL_B, SL_H, SL_W: bad = 1'b0;
      SL_BU, SL_HU:     bad = sltype[SL_STORE_BIT];
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Halfwords need even offsets, words need offset zero.
  function automatic logic is_misaligned(logic [2:0] sltype, logic [OFF_W-1:0] offset);
    logic mis;
    case (sltype)
      SL_H, SL_HU: mis = offset[0];
      SL_W:        mis = (offset != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_rmw_ctrl_if.sv
// LSU request/response and data-memory port bundle for the RMW controller.
interface dmem_rmw_ctrl_if
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
);

  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [SLT_W-1:0]  req_sltype;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Controller side.
  modport slave (
    input  req_valid, req_addr, req_wdata, req_sltype, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );

  // LSU plus memory side.
  modport master (
    output req_valid, req_addr, req_wdata, req_sltype, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte/half lane extraction with extension for loads, and lane merge for sub-word stores.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [OFF_W-1:0]  offset_i,
  input  logic [2:0]        sltype_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] ld_data_c_o,
  output logic [DATA_W-1:0] merge_word_c_o
);

  logic [4:0]        shamt;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] byte_mask;
  logic [DATA_W-1:0] half_mask;

  assign shamt     = {offset_i, 3'b000};
  assign shifted   = word_i >> shamt;
  assign byte_mask = DATA_W'(32'h0000_00FF) << shamt;
  assign half_mask = DATA_W'(32'h0000_FFFF) << shamt;

  // Little-endian lane select, then sign or zero extension.
  always_comb begin
    ld_data_c_o = word_i;
    case (sltype_i)
      SL_B:    ld_data_c_o = {{24{shifted[7]}}, shifted[7:0]};
      SL_BU:   ld_data_c_o = {24'h0, shifted[7:0]};
      SL_H:    ld_data_c_o = {{16{shifted[15]}}, shifted[15:0]};
      SL_HU:   ld_data_c_o = {16'h0, shifted[15:0]};
      default: ld_data_c_o = word_i;
    endcase
  end

  // Replace the addressed lane(s) of the old word with right-aligned store data.
  always_comb begin
    merge_word_c_o = word_i;
    case (sltype_i)
      SL_B, SL_BU: merge_word_c_o = (word_i & ~byte_mask) | (DATA_W'(wdata_i[7:0]) << shamt);
      SL_H, SL_HU: merge_word_c_o = (word_i & ~half_mask) | (DATA_W'(wdata_i[15:0]) << shamt);
      SL_W:        merge_word_c_o = wdata_i;
      default:     merge_word_c_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// LSU-to-word-memory sequencer: loads, word stores, and sub-word stores as read-modify-write.
module dmem_rmw_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  dmem_rmw_ctrl_if.slave   bus
);

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic              ready_q, ready_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rerr_q, rerr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;

  logic [ADDR_W-1:0] req_idx;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] merge_word;
  logic              req_bad;
  logic              unused_addr_hi;

  assign req_idx        = bus.req_addr[ADDR_W+1:2];
  assign req_bad        = is_illegal(bus.req_sltype) ||
                          is_misaligned(bus.req_sltype[2:0], bus.req_addr[1:0]);
  assign unused_addr_hi = ^bus.req_addr[DATA_W-1:ADDR_W+2];

  dmem_lane_align u_lane_align (
    .word_i         (bus.mem_rdata),
    .offset_i       (req_q.offset),
    .sltype_i       (req_q.sltype[2:0]),
    .wdata_i        (req_q.wdata),
    .ld_data_c_o    (ld_data),
    .merge_word_c_o (merge_word)
  );

  // State and registered outputs; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
      we_q     <= we_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          req_d.offset = bus.req_addr[1:0];
          req_d.sltype = bus.req_sltype;
          req_d.wdata  = bus.req_wdata;
          if (req_bad) begin
            rdata_d = '0;
            rerr_d  = 1'b1;
            state_d = ST_RESP;
          end else begin
            rerr_d  = 1'b0;
            maddr_d = req_idx;
            if (!bus.req_sltype[SL_STORE_BIT]) begin
              state_d = ST_LOAD;
            end else if (bus.req_sltype[2:0] == SL_W) begin
              mwdata_d = bus.req_wdata;
              state_d  = ST_WRITE;
            end else begin
              state_d = ST_READ;
            end
          end
        end
      end
      ST_LOAD: begin
        rdata_d = ld_data;
        state_d = ST_RESP;
      end
      ST_READ: begin
        mwdata_d = merge_word;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        rdata_d = '0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d  = (state_d == ST_IDLE);
    rvalid_d = (state_d == ST_RESP);
    we_d     = (state_d == ST_WRITE);
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = rvalid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = rerr_q;
  assign bus.mem_addr   = maddr_q;
  assign bus.mem_wdata  = mwdata_q;
  assign bus.mem_we     = we_q;

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Randomized and directed bench for dmem_rmw_ctrl against a byte-level reference memory.
module tb_dmem_rmw_ctrl;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 256;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   we_cnt  = 0;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  dmem_rmw_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_rmw_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Word memory: combinational read, write on posedge.
  always_comb bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      we_cnt            <= we_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: access rules applied to a byte view of the memory.
  function automatic void model(input logic [31:0] addr, input logic [31:0] wd,
                                input logic [3:0] slt, output logic [31:0] rd,
                                output logic err, output int lat, output int nwr);
    int          off, idx, size, op;
    bit          store;
    logic [31:0] word, mask;
    off   = int'(addr % 4);
    idx   = int'((addr / 4) % DEPTH);
    op    = int'(slt[2:0]);
    store = slt[3];
    size  = (op == 0 || op == 4) ? 1 : (op == 1 || op == 5) ? 2 : 4;
    err   = !(op inside {0, 1, 2, 4, 5}) || (store && op >= 4) || (off % size != 0);
    rd    = '0;
    nwr   = 0;
    if (err) begin
      lat = 1;
    end else if (!store) begin
      word = ref_mem[idx];
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      rd   = (word >> (8 * off)) & mask;
      if (op < 4 && size < 4 && rd[8 * size - 1]) rd = rd | ~mask;
      lat  = 2;
    end else begin
      for (int i = 0; i < size; i++) ref_mem[idx][8 * (off + i) +: 8] = wd[8 * i +: 8];
      lat = (size == 4) ? 2 : 3;
      nwr = 1;
    end
  endfunction

  // One full transaction with latency, data, back-pressure and memory checks.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] slt,
                        input int hold, output logic [31:0] got);
    logic [31:0] erd;
    logic        eerr;
    int          elat, enwr, lat, w0, idx;
    model(addr, wd, slt, erd, eerr, elat, enwr);
    idx = int'((addr / 4) % DEPTH);
    @(negedge clk);
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_sltype = slt;
    w0 = we_cnt;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_sltype = 4'($urandom);
    lat = 1;
    while (!bus.resp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("latency", 32'(lat), 32'(elat));
    chk("resp_rdata", bus.resp_rdata, erd);
    chk("resp_err", 32'(bus.resp_err), 32'(eerr));
    chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
    got = bus.resp_rdata;
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("hold_rdata", bus.resp_rdata, erd);
      chk("hold_err", 32'(bus.resp_err), 32'(eerr));
      chk("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    chk("idle_ready", 32'(bus.req_ready), 32'd1);
    chk("idle_valid", 32'(bus.resp_valid), 32'd0);
    chk("we_pulses", 32'(we_cnt - w0), 32'(enwr));
    chk("mem_word", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    logic [31:0] got, addr;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_sltype = '0;
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Word store then load back.
    do_req(32'h10, 32'hAABB_CCDD, 4'b1010, 0, got);
    chk("sw_word", mem[4], 32'hAABB_CCDD);
    do_req(32'h10, 32'h0, 4'b0010, 0, got);
    chk("lw_data", got, 32'hAABB_CCDD);

    // Sub-word stores.
    do_req(32'h20, 32'h1122_3344, 4'b1010, 0, got);
    do_req(32'h22, 32'h0000_00EE, 4'b1000, 0, got);
    chk("sb_merge", mem[8], 32'h11EE_3344);
    do_req(32'h20, 32'h0000_BEEF, 4'b1001, 0, got);
    chk("sh_merge", mem[8], 32'h11EE_BEEF);

    // Extension cases.
    do_req(32'h30, 32'h80F0_7F81, 4'b1010, 0, got);
    do_req(32'h30, 32'h0, 4'b0000, 0, got);
    chk("lb", got, 32'hFFFF_FF81);
    do_req(32'h30, 32'h0, 4'b0100, 0, got);
    chk("lbu", got, 32'h0000_0081);
    do_req(32'h32, 32'h0, 4'b0001, 0, got);
    chk("lh", got, 32'hFFFF_80F0);
    do_req(32'h32, 32'h0, 4'b0101, 0, got);
    chk("lhu", got, 32'h0000_80F0);

    // Errors.
    do_req(32'h31, 32'h0, 4'b0010, 0, got);
    do_req(32'h23, 32'h1234, 4'b1001, 0, got);
    do_req(32'h30, 32'h0, 4'b0111, 0, got);
    do_req(32'h30, 32'h55, 4'b1100, 0, got);
    chk("err_mem_unchanged", mem[12], 32'h80F0_7F81);

    // Back-pressure.
    do_req(32'h30, 32'h0, 4'b0000, 5, got);

    // Reset in the middle of a sub-word store.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h24;
    bus.req_wdata  = 32'h55;
    bus.req_sltype = 4'b1000;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("mid_rst_we", 32'(bus.mem_we), 32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("mid_rst_wdata", bus.mem_wdata, 32'd0);
    chk("mid_rst_rdata", bus.resp_rdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_word", mem[9], ref_mem[9]);
    do_req(32'h24, 32'h0, 4'b0010, 0, got);

    // Random traffic, including ignored upper address bits and illegal codes.
    for (int k = 0; k < 150; k++) begin
      addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      do_req(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_rmw_ctrl.md
Name: dmem_rmw_ctrl

Overview:
- Sequencing controller between the core load/store unit and the word-wide data memory.
- The memory supports only whole-word writes, so sub-word stores (sb/sh) run here as read-modify-write.
- Loads are extracted and sign/zero-extended per SLType; misaligned and illegal accesses are flagged.
- Uses a valid/ready request-response handshake and sits between the LSU and the 256x32 data memory array.

Parameters:
- ADDR_W, 8, width of word index driven to memory (depth = 2^ADDR_W words).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  LSU request valid.
- req_ready  out  1  controller can accept request (high only in IDLE).
- req_addr  in  32  byte address; word index = req_addr[ADDR_W+1:2], upper bits ignored.
- req_wdata  in  32  store data (right-aligned for sb/sh).
- req_sltype  in  4  [3]=1 store / 0 load; [2:0]: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- resp_valid  out  1  response valid.
- resp_ready  in  1  LSU accepts response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal access.
- mem_addr  out  ADDR_W  word index to memory.
- mem_wdata  out  32  full word to write.
- mem_we  out  1  memory write enable (memory writes on posedge clk).
- mem_rdata  in  32  combinational read data for mem_addr.

Behaviour:
- Reset (async, any state): state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0. req_ready=1 after reset. A reset during WRITE suppresses the write; no partial op is resumed.
- States: IDLE, LOAD, READ, WRITE, RESP. req_ready = (state==IDLE). mem_we=1 only in WRITE.
- Acceptance: in IDLE, req_valid=1 latches addr, wdata, sltype and offset = addr[1:0].
- Illegal sltype ([2:0] in 011, 110, 111; or store with [2]=1) -> RESP with resp_err=1.
- Misaligned access (h/hu with offset[0]=1; w with offset!=0) -> RESP with resp_err=1.
- Any error goes to RESP next cycle with rdata=0 and no memory access.
- Load -> LOAD: mem_addr = latched index.
  - Extract byte/half little-endian at offset*8.
  - Extend: b/h sign, bu/hu zero, w passthrough.
  - Register into resp_rdata -> RESP.
- sw -> WRITE: mem_wdata = wdata -> RESP.
- sb/sh -> READ: capture mem_rdata into merge register; replace lane(s) at offset with wdata[7:0]/[15:0] -> WRITE with merged word -> RESP.
- RESP: resp_valid=1, resp_rdata/resp_err held stable until resp_ready=1, then IDLE. A new request is not accepted in the same cycle.
- Latency (accept edge = T):
  - error: resp_valid at T+1.
  - load and sw: resp_valid at T+2.
  - sb/sh: resp_valid at T+3.
- mem_addr holds the latched index from LOAD through WRITE; in IDLE/RESP it holds its last value.
- Back-pressure: resp_ready=0 holds RESP indefinitely; req_ready stays 0.

Decomposition:
- Package dmem_pkg:
  - sltype encodings (SL_B, SL_H, SL_W, SL_BU, SL_HU, store bit index).
  - state enum.
  - function is_misaligned(sltype, offset).
- One combinational sub-module, dmem_lane_align.
  - Inputs: word, offset, sltype[2:0], wdata.
  - Outputs: extended load data and merged store word.
  - Shared by the LOAD and READ/WRITE paths.

Test Plan:
- Store: sw addr 0x10, data 0xAABBCCDD; then lw 0x10 -> one write of 0xAABBCCDD at mem_addr 4; load resp_rdata=0xAABBCCDD, err=0, resp at T+2.
- Sub-word stores: word 0x11223344 at 0x20; sb 0x22 data 0x000000EE -> memory word 0x11EE3344; sh 0x20 data 0xBEEF -> 0x11EEBEEF. Each resp at T+3 with exactly one mem_we pulse.
- Loads: word 0x80F0_7F81 at 0x30:
  - lb 0x30 -> 0xFFFFFF81.
  - lbu 0x30 -> 0x00000081.
  - lh 0x32 -> 0xFFFF80F0.
  - lhu 0x32 -> 0x000080F0.
- Errors: lw 0x31, sh 0x23, sltype 0111 -> resp_err=1, rdata=0, resp at T+1, mem_we never asserted, memory unchanged.
- Back-pressure: hold resp_ready=0 for 5 cycles after lb -> resp_valid and rdata stable, req_ready=0; release -> IDLE the next cycle.
- Reset: assert rst during READ of an sb -> all outputs reset values immediately, target word unchanged, next request handled normally.
